// File: rtl/bp_fpga_host_nbf_tx_arb_if.sv
// Bus bundle for the NBF transmit arbiter: two packet requesters in, one UART byte stream out.
interface bp_fpga_host_nbf_tx_arb_if #(
  parameter int nbf_width_p = 112
);
  logic [nbf_width_p-1:0] nbf0_i;
  logic                   nbf0_v_i;
  logic                   nbf0_ready_and_o;
  logic [nbf_width_p-1:0] nbf1_i;
  logic                   nbf1_v_i;
  logic                   nbf1_ready_and_o;
  logic [7:0]             byte_o;
  logic                   byte_v_o;
  logic                   byte_ready_and_i;
  logic                   grant_id_o;
  logic                   busy_o;

  modport slave (
    input  nbf0_i, nbf0_v_i, nbf1_i, nbf1_v_i, byte_ready_and_i,
    output nbf0_ready_and_o, nbf1_ready_and_o, byte_o, byte_v_o, grant_id_o, busy_o
  );

  modport master (
    output nbf0_i, nbf0_v_i, nbf1_i, nbf1_v_i, byte_ready_and_i,
    input  nbf0_ready_and_o, nbf1_ready_and_o, byte_o, byte_v_o, grant_id_o, busy_o
  );
endinterface

// File: rtl/bp_fpga_host_nbf_tx_arb.sv
// Packet-atomic round-robin arbiter between two NBF sources, serializing the
// granted packet LSB-first onto the UART byte stream.
module bp_fpga_host_nbf_tx_arb #(
  parameter int nbf_addr_width_p = 40,
  parameter int nbf_data_width_p = 64,
  parameter int uart_data_bits_p = 8
) (
  input logic clk_i,
  input logic reset_i,
  bp_fpga_host_nbf_tx_arb_if.slave bus
);
  localparam int nbf_width_lp = 8 + nbf_addr_width_p + nbf_data_width_p;
  localparam int nbf_bytes_lp = nbf_width_lp / uart_data_bits_p;
  localparam logic [3:0] last_cnt_lp = 4'(nbf_bytes_lp - 1);

  localparam logic [0:0] e_idle = 1'b0;
  localparam logic [0:0] e_send = 1'b1;

  logic [0:0]              state_q, state_d;
  logic                    rr_q, rr_d;
  logic                    grant_q, grant_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [nbf_width_lp-1:0] shift_q, shift_d;

  logic idle, send, any_v, sel, accept, byte_hs;

  // Outputs are gated by reset so the reset cycle itself presents a quiet bus.
  assign idle   = (state_q == e_idle) & ~reset_i;
  assign send   = (state_q == e_send) & ~reset_i;
  assign any_v  = bus.nbf0_v_i | bus.nbf1_v_i;
  assign sel    = (bus.nbf0_v_i & bus.nbf1_v_i) ? rr_q : bus.nbf1_v_i;

  assign bus.nbf0_ready_and_o = idle & any_v & ~sel;
  assign bus.nbf1_ready_and_o = idle & any_v &  sel;
  assign accept  = (bus.nbf0_ready_and_o & bus.nbf0_v_i)
                 | (bus.nbf1_ready_and_o & bus.nbf1_v_i);

  assign bus.byte_o     = shift_q[7:0];
  assign bus.byte_v_o   = send;
  assign bus.busy_o     = send;
  assign bus.grant_id_o = grant_q & ~reset_i;
  assign byte_hs        = send & bus.byte_ready_and_i;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (accept) begin
      shift_d = sel ? bus.nbf1_i : bus.nbf0_i;
      grant_d = sel;
      cnt_d   = '0;
      state_d = e_send;
    end else if (byte_hs) begin
      shift_d = {8'b0, shift_q[nbf_width_lp-1:8]};
      if (cnt_q == last_cnt_lp) begin
        state_d = e_idle;
        rr_d    = ~grant_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      rr_q    <= 1'b0;
      grant_q <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end
endmodule

// File: tb/tb_bp_fpga_host_nbf_tx_arb.sv
// Randomized scoreboard bench for the NBF transmit arbiter.
module tb_bp_fpga_host_nbf_tx_arb;
  localparam int W = 112;
  localparam int NB = 14;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bp_fpga_host_nbf_tx_arb_if #(.nbf_width_p(W)) bus ();

  bp_fpga_host_nbf_tx_arb #(
    .nbf_addr_width_p(40),
    .nbf_data_width_p(64),
    .uart_data_bits_p(8)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [8:0] exp_q[$];
  logic       m_busy = 1'b0, m_rr = 1'b0, m_grant = 1'b0;
  int         m_left = 0;
  logic       acc0 = 1'b0, acc1 = 1'b0;
  int         p0 = 0, p1 = 0, prdy = 100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packet-level arbitration; on each grant the whole expected
  // byte stream of the packet is queued for the monitor.
  always @(negedge clk) begin
    logic e0, e1;
    logic [W-1:0] pkt;
    if (rst) begin
      check("rst_ready0", bus.nbf0_ready_and_o, 0);
      check("rst_ready1", bus.nbf1_ready_and_o, 0);
      check("rst_byte_v", bus.byte_v_o, 0);
      check("rst_busy", bus.busy_o, 0);
      check("rst_grant", bus.grant_id_o, 0);
      m_busy = 1'b0;
      m_rr   = 1'b0;
      m_left = 0;
      exp_q.delete();
    end else begin
      e0 = !m_busy && bus.nbf0_v_i && (!bus.nbf1_v_i || !m_rr);
      e1 = !m_busy && bus.nbf1_v_i && (!bus.nbf0_v_i || m_rr);
      check("ready0", bus.nbf0_ready_and_o, e0);
      check("ready1", bus.nbf1_ready_and_o, e1);
      check("byte_v", bus.byte_v_o, m_busy);
      check("busy", bus.busy_o, m_busy);
      if (m_busy) check("grant_id", bus.grant_id_o, m_grant);
      if (e0 || e1) begin
        pkt = e0 ? bus.nbf0_i : bus.nbf1_i;
        m_grant = e1;
        for (int k = 0; k < NB; k++) exp_q.push_back({e1, pkt[8*k +: 8]});
        m_busy = 1'b1;
        m_left = NB;
        if (e0) acc0 = 1'b1; else acc1 = 1'b1;
      end else if (m_busy && bus.byte_ready_and_i) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_rr   = !m_grant;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every byte handshake; checks stalled bytes hold.
  logic       hold_pend = 1'b0;
  logic [7:0] hold_byte;
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_stable", {bus.byte_v_o, bus.byte_o}, {1'b1, hold_byte});
        hold_pend = 1'b0;
      end
      if (bus.byte_v_o && bus.byte_ready_and_i) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_byte: got %0h expected none at %0t", bus.byte_o, $time);
        end else begin
          e = exp_q.pop_front();
          check("byte", bus.byte_o, e[7:0]);
          check("byte_grant", bus.grant_id_o, e[8]);
        end
      end else if (bus.byte_v_o) begin
        hold_pend = 1'b1;
        hold_byte = bus.byte_o;
      end
    end
  end

  function automatic logic [W-1:0] rnd_pkt();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (acc0) begin acc0 = 1'b0; bus.nbf0_v_i = 1'b0; end
    if (acc1) begin acc1 = 1'b0; bus.nbf1_v_i = 1'b0; end
    if (!bus.nbf0_v_i && $urandom_range(99, 0) < p0) begin
      bus.nbf0_v_i = 1'b1;
      bus.nbf0_i   = rnd_pkt();
    end
    if (!bus.nbf1_v_i && $urandom_range(99, 0) < p1) begin
      bus.nbf1_v_i = 1'b1;
      bus.nbf1_i   = rnd_pkt();
    end
    bus.byte_ready_and_i = ($urandom_range(99, 0) < prdy);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    bus.nbf0_v_i = 1'b0;
    bus.nbf1_v_i = 1'b0;
    bus.nbf0_i = '0;
    bus.nbf1_i = '0;
    bus.byte_ready_and_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run(1);

    // Single directed packet from requester 0.
    bus.nbf0_i   = {64'h1122334455667788, 40'h00_8000_0000, 8'h02};
    bus.nbf0_v_i = 1'b1;
    p0 = 0; p1 = 0; prdy = 100;
    run(20);

    // Contention: both always valid.
    p0 = 100; p1 = 100;
    run(120);

    // Lone requester 1, then a tie.
    p0 = 0; p1 = 100;
    run(60);
    p0 = 100;
    run(40);

    // Backpressure and random traffic with late arrivals.
    p0 = 30; p1 = 30; prdy = 45;
    run(1500);
    prdy = 100;
    run(200);

    // Reset in the middle of a packet, just before byte 7.
    p0 = 0; p1 = 100; prdy = 100;
    waited = 0;
    while (!(m_busy && m_left == NB - 7) && waited < 300) begin
      step();
      waited++;
    end
    if (waited >= 300) begin
      tests++;
      fails++;
      $display("FAIL reset_window: got timeout expected byte 7 in flight");
    end
    rst = 1'b1;
    bus.nbf0_v_i = 1'b0;
    bus.nbf1_v_i = 1'b0;
    acc0 = 1'b0;
    acc1 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    p1 = 0;
    run(2);
    p0 = 40; p1 = 40; prdy = 60;
    run(600);

    // Drain everything outstanding.
    p0 = 0; p1 = 0; prdy = 100;
    run(80);
    check("drain_queue", exp_q.size(), 0);
    check("drain_busy", bus.busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
